jump_lut: RTL and testbench
===========================

JUMP_LUT -- requirements
Module: jump_lut

Interface
REQ-001 SHALL have parameter W, default 10, meaning target width in bits, legal range 1..32.
REQ-002 SHALL have parameter A, default 4, meaning address width; depth is 2**A entries.
REQ-003 SHALL have ports: clk  in  1  sole clock; Reset  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: Write_En  in  1  load beat strobe; Load_Start  in  1  first beat of a new entry load.
REQ-005 SHALL have ports: Imm_in  in  A  entry address, sampled only on Load_Start beats; Acc_in  in  8  load byte.
REQ-006 SHALL have ports: Clear  in  1  invalidate all entries; Rd_En  in  1  lookup strobe; Rd_Addr  in  A  lookup address.
REQ-007 SHALL have ports: Target  out  W  registered lookup data; Target_Valid  out  1  looked-up entry valid; Load_Busy  out  1  mid-load; Load_Err  out  1  one-cycle abort pulse.

Function
REQ-008 SHALL load each entry as NC = ceil(W/8) byte beats, least-significant byte first; the last beat uses only its low W-8*(NC-1) bits.
REQ-009 SHALL have FSM states IDLE and LOAD; Load_Busy SHALL be 1 exactly in LOAD.
REQ-010 SHALL, in IDLE, ignore Write_En beats without Load_Start.
REQ-011 SHALL, on Write_En & Load_Start, capture Imm_in and byte 0 into a staging register; if NC=1, commit on that edge and stay IDLE, else go to LOAD with beat count 1.
REQ-012 SHALL, in LOAD, write byte N of staging on each Write_En beat without Load_Start; Write_En=0 holds state.
REQ-013 SHALL, on the final beat (count NC-1), write the fully assembled value to the table, set the entry valid bit on that same edge, and return to IDLE.
REQ-014 SHALL leave the table entry unchanged until commit; a partial load is never visible to lookups.
REQ-015 SHALL, on Write_En & Load_Start while in LOAD, discard the partial load, pulse Load_Err for one cycle, and restart per REQ-011 at the new address.
REQ-016 SHALL, on Clear, zero every valid bit, abort any load without a Load_Err pulse, go to IDLE, and leave data contents unchanged; Clear has priority over all load beats in the same cycle.
REQ-017 SHALL, on Rd_En, update Target and Target_Valid from Rd_Addr on the next edge (one-cycle latency); Rd_En=0 holds both outputs.
REQ-018 SHALL forward write-first: when a commit and Rd_En address the same entry in the same cycle, Target and Target_Valid SHALL show the committed value and 1.
REQ-019 SHALL, when Clear and Rd_En coincide, register Target_Valid=0 and Target from the stored data.

Reset
REQ-020 SHALL, on Reset, zero all table data and valid bits, Target, Target_Valid, Load_Err and staging, and force IDLE.
REQ-021 SHALL give Reset priority over Clear, loads and lookups; a load interrupted by Reset is lost without a Load_Err pulse.

Structure
REQ-022 SHALL place the FSM state typedef (IDLE, LOAD) and the NC chunk-count function in package jump_lut_pkg.
REQ-023 SHALL implement the beat counter, staging register and FSM as one sub-module, jump_lut_loader, which emits the commit strobe, commit address and commit data.
REQ-024 SHALL keep the table, valid bits and read register in jump_lut.

Verification
REQ-025 SHALL cover W=10, A=4: Load_Start at address 3 with byte 0xA5, then byte 0x02, then Rd_En address 3 -> Target=0x2A5 and Target_Valid=1 one cycle later.
REQ-026 SHALL cover a partial load: address 5, first beat only, then Rd_En address 5 -> Target=0, Target_Valid=0, Load_Busy=1.
REQ-027 SHALL cover an abort: Load_Start at address 5, then Load_Start at address 6 with 0x11, then 0x01 -> Load_Err high for exactly one cycle, entry 6 = 0x111, entry 5 still invalid.
REQ-028 SHALL cover forwarding: the final beat to address 7 (0x3FF) in the same cycle as Rd_En address 7 -> Target=0x3FF and Target_Valid=1 on the next edge.
REQ-029 SHALL cover Clear: Clear mid-load and after loads -> all Target_Valid=0, Load_Busy=0, no Load_Err pulse, old data still readable.
REQ-030 SHALL cover W=24 and W=8: 3-beat and 1-beat loads commit correctly, and Reset mid-load returns all outputs to 0.

Source files
------------

// File: rtl/jump_lut_pkg.sv
// -----------------------------------------------------------------------------
// jump_lut_pkg
// Shared definitions for the jump lookup table:
//   - load_state_t : loader FSM states (IDLE, LOAD)
//   - chunk_count  : number of byte beats needed to load a W-bit entry
// -----------------------------------------------------------------------------
package jump_lut_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } load_state_t;

  // Beats per entry: ceil(w / 8).
  function automatic int chunk_count(input int w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/jump_lut_loader.sv
// -----------------------------------------------------------------------------
// jump_lut_loader
// Assembles one table entry from byte beats (least-significant byte first) and
// emits a single-cycle commit strobe with the entry address and data once the
// final beat arrives.
//
// Ports:
//   clk             in  1  clock
//   Reset           in  1  synchronous active-high reset
//   i_write_en      in  1  load beat strobe
//   i_load_start    in  1  first beat of a new entry load
//   i_addr          in  A  entry address, sampled on start beats
//   i_byte          in  8  load byte
//   i_clear         in  1  abort any load silently
//   o_commit        out 1  entry complete this cycle (combinational)
//   o_commit_addr   out A  address of the committing entry
//   o_commit_data   out W  fully assembled entry value
//   o_busy          out 1  mid-load (state LOAD)
//   o_err           out 1  one-cycle pulse after a load was restarted
// -----------------------------------------------------------------------------
module jump_lut_loader
  import jump_lut_pkg::*;
#(
  parameter int W = 10,
  parameter int A = 4
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         i_write_en,
  input  logic         i_load_start,
  input  logic [A-1:0] i_addr,
  input  logic [7:0]   i_byte,
  input  logic         i_clear,
  output logic         o_commit,
  output logic [A-1:0] o_commit_addr,
  output logic [W-1:0] o_commit_data,
  output logic         o_busy,
  output logic         o_err
);

  localparam int NC = chunk_count(W);
  localparam int CW = (NC > 1) ? $clog2(NC) : 1;

  load_state_t   r_state, w_state_next;
  logic [CW-1:0] r_cnt,   w_cnt_next;
  logic [A-1:0]  r_addr,  w_addr_next;
  logic [W-1:0]  r_stage, w_stage_next;
  logic          r_err,   w_err_next;

  // Drop byte b into chunk idx of cur; bits of the last chunk beyond W are
  // simply discarded.
  function automatic logic [W-1:0] place_byte(input logic [W-1:0] cur,
                                               input int          idx,
                                               input logic [7:0]  b);
    logic [W-1:0] v;
    v = cur;
    for (int i = 0; i < W; i++) begin
      if (i / 8 == idx) v[i] = b[i % 8];
    end
    return v;
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_addr_next   = r_addr;
    w_stage_next  = r_stage;
    w_err_next    = 1'b0;
    o_commit      = 1'b0;
    o_commit_addr = r_addr;
    o_commit_data = r_stage;

    if (i_clear) begin
      // Clear outranks any beat in the same cycle and aborts without an error.
      w_state_next = IDLE;
      w_cnt_next   = '0;
    end else if (i_write_en && i_load_start) begin
      // A start beat in LOAD discards the partial entry and flags the abort.
      w_err_next   = (r_state == LOAD);
      w_addr_next  = i_addr;
      w_stage_next = place_byte('0, 0, i_byte);
      if (NC == 1) begin
        o_commit      = 1'b1;
        o_commit_addr = i_addr;
        o_commit_data = w_stage_next;
        w_state_next  = IDLE;
        w_cnt_next    = '0;
      end else begin
        w_state_next = LOAD;
        w_cnt_next   = CW'(1);
      end
    end else if (i_write_en && (r_state == LOAD)) begin
      w_stage_next = place_byte(r_stage, int'(r_cnt), i_byte);
      if (r_cnt == CW'(NC - 1)) begin
        o_commit      = 1'b1;
        o_commit_addr = r_addr;
        o_commit_data = w_stage_next;
        w_state_next  = IDLE;
        w_cnt_next    = '0;
      end else begin
        w_cnt_next = r_cnt + CW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_stage <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_addr  <= w_addr_next;
      r_stage <= w_stage_next;
      r_err   <= w_err_next;
    end
  end

  assign o_busy = (r_state == LOAD);
  assign o_err  = r_err;

endmodule

// File: rtl/jump_lut.sv
// -----------------------------------------------------------------------------
// jump_lut
// Small jump-target lookup table. Entries are loaded byte-serially through
// jump_lut_loader and become visible only when fully assembled. Lookups have
// one cycle of latency and forward a same-cycle commit (write-first).
//
// Ports:
//   clk           in  1  sole clock
//   Reset         in  1  synchronous active-high reset
//   Write_En      in  1  load beat strobe
//   Load_Start    in  1  first beat of a new entry load
//   Imm_in        in  A  entry address (start beats only)
//   Acc_in        in  8  load byte
//   Clear         in  1  invalidate all entries, abort any load
//   Rd_En         in  1  lookup strobe
//   Rd_Addr       in  A  lookup address
//   Target        out W  registered lookup data
//   Target_Valid  out 1  looked-up entry valid
//   Load_Busy     out 1  mid-load
//   Load_Err      out 1  one-cycle abort pulse
// -----------------------------------------------------------------------------
module jump_lut
  import jump_lut_pkg::*;
#(
  parameter int W = 10,
  parameter int A = 4
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         Write_En,
  input  logic         Load_Start,
  input  logic [A-1:0] Imm_in,
  input  logic [7:0]   Acc_in,
  input  logic         Clear,
  input  logic         Rd_En,
  input  logic [A-1:0] Rd_Addr,
  output logic [W-1:0] Target,
  output logic         Target_Valid,
  output logic         Load_Busy,
  output logic         Load_Err
);

  localparam int DEPTH = 1 << A;

  logic         w_commit;
  logic [A-1:0] w_commit_addr;
  logic [W-1:0] w_commit_data;

  logic [W-1:0]     r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [W-1:0]     r_target;
  logic             r_target_valid;

  jump_lut_loader #(
    .W (W),
    .A (A)
  ) u_loader (
    .clk           (clk),
    .Reset         (Reset),
    .i_write_en    (Write_En),
    .i_load_start  (Load_Start),
    .i_addr        (Imm_in),
    .i_byte        (Acc_in),
    .i_clear       (Clear),
    .o_commit      (w_commit),
    .o_commit_addr (w_commit_addr),
    .o_commit_data (w_commit_data),
    .o_busy        (Load_Busy),
    .o_err         (Load_Err)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      // NOTE: the table is a small flop array that must come up all-zero, so
      // it is reset explicitly; this would not map onto an SRAM macro.
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
      r_valid        <= '0;
      r_target       <= '0;
      r_target_valid <= 1'b0;
    end else begin
      if (Clear) r_valid <= '0;
      // The loader never commits in a Clear cycle, so the two cannot collide.
      if (w_commit) begin
        r_data[w_commit_addr]  <= w_commit_data;
        r_valid[w_commit_addr] <= 1'b1;
      end
      if (Rd_En) begin
        if (w_commit && (w_commit_addr == Rd_Addr)) begin
          r_target       <= w_commit_data;
          r_target_valid <= 1'b1;
        end else begin
          r_target       <= r_data[Rd_Addr];
          r_target_valid <= r_valid[Rd_Addr] & ~Clear;
        end
      end
    end
  end

  assign Target       = r_target;
  assign Target_Valid = r_target_valid;

endmodule

// File: tb/tb_jump_lut.sv
// -----------------------------------------------------------------------------
// tb_jump_lut
// Drives three jump_lut instances (W=10, W=24, W=8; A=4) from one shared
// stimulus stream. A behavioural model per instance tracks the collected
// bytes and the table contents, and every cycle all outputs are compared.
// Directed steps additionally check hand-computed constants.
// -----------------------------------------------------------------------------
module tb_jump_lut;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       Reset = 1'b0, Write_En = 1'b0, Load_Start = 1'b0;
  logic       Clear = 1'b0, Rd_En = 1'b0;
  logic [3:0] Imm_in = '0, Rd_Addr = '0;
  logic [7:0] Acc_in = '0;

  logic [9:0]  t0;
  logic [23:0] t1;
  logic [7:0]  t2;
  logic [2:0]  tv, busy, err;

  jump_lut #(.W(10), .A(4)) dut0 (
    .clk(clk), .Reset(Reset), .Write_En(Write_En), .Load_Start(Load_Start),
    .Imm_in(Imm_in), .Acc_in(Acc_in), .Clear(Clear), .Rd_En(Rd_En),
    .Rd_Addr(Rd_Addr), .Target(t0), .Target_Valid(tv[0]),
    .Load_Busy(busy[0]), .Load_Err(err[0]));

  jump_lut #(.W(24), .A(4)) dut1 (
    .clk(clk), .Reset(Reset), .Write_En(Write_En), .Load_Start(Load_Start),
    .Imm_in(Imm_in), .Acc_in(Acc_in), .Clear(Clear), .Rd_En(Rd_En),
    .Rd_Addr(Rd_Addr), .Target(t1), .Target_Valid(tv[1]),
    .Load_Busy(busy[1]), .Load_Err(err[1]));

  jump_lut #(.W(8), .A(4)) dut2 (
    .clk(clk), .Reset(Reset), .Write_En(Write_En), .Load_Start(Load_Start),
    .Imm_in(Imm_in), .Acc_in(Acc_in), .Clear(Clear), .Rd_En(Rd_En),
    .Rd_Addr(Rd_Addr), .Target(t2), .Target_Valid(tv[2]),
    .Load_Busy(busy[2]), .Load_Err(err[2]));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, one slot per instance.
  longint unsigned m_data  [3][16];
  bit              m_valid [3][16];
  longint unsigned m_tgt   [3];
  bit              m_tv    [3];
  bit              m_busy  [3];
  bit              m_err   [3];
  int              m_addr  [3];
  int              m_nb    [3];
  longint unsigned m_acc   [3];

  function automatic int width_of(input int d);
    case (d)
      0:       return 10;
      1:       return 24;
      default: return 8;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Advance the model of instance d across one clock edge using the
  // currently applied inputs.
  task automatic model_step(input int d);
    int              w;
    int              nc;
    longint unsigned mask;
    bit              commit;
    longint unsigned cval;
    int              caddr;
    w      = width_of(d);
    nc     = (w + 7) / 8;
    mask   = (64'd1 << w) - 64'd1;
    commit = 1'b0;
    cval   = 0;
    caddr  = 0;
    if (Reset) begin
      for (int i = 0; i < 16; i++) begin
        m_data[d][i]  = 0;
        m_valid[d][i] = 1'b0;
      end
      m_tgt[d]  = 0;
      m_tv[d]   = 1'b0;
      m_busy[d] = 1'b0;
      m_err[d]  = 1'b0;
      m_nb[d]   = 0;
      m_acc[d]  = 0;
      return;
    end
    m_err[d] = 1'b0;
    if (Clear) begin
      for (int i = 0; i < 16; i++) m_valid[d][i] = 1'b0;
      m_busy[d] = 1'b0;
    end else if (Write_En && Load_Start) begin
      m_err[d]  = m_busy[d];
      m_addr[d] = int'(Imm_in);
      m_acc[d]  = longint'(Acc_in);
      m_nb[d]   = 1;
      m_busy[d] = 1'b1;
    end else if (Write_En && m_busy[d]) begin
      m_acc[d] = m_acc[d] | (longint'(Acc_in) << (8 * m_nb[d]));
      m_nb[d]++;
    end
    if (m_busy[d] && m_nb[d] == nc) begin
      commit    = 1'b1;
      cval      = m_acc[d] & mask;
      caddr     = m_addr[d];
      m_busy[d] = 1'b0;
    end
    if (Rd_En) begin
      if (commit && caddr == int'(Rd_Addr)) begin
        m_tgt[d] = cval;
        m_tv[d]  = 1'b1;
      end else begin
        m_tgt[d] = m_data[d][Rd_Addr];
        m_tv[d]  = m_valid[d][Rd_Addr];
      end
    end
    if (commit) begin
      m_data[d][caddr]  = cval;
      m_valid[d][caddr] = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("w10_target", {22'b0, t0}, 32'(m_tgt[0]));
    check("w24_target", {8'b0, t1},  32'(m_tgt[1]));
    check("w8_target",  {24'b0, t2}, 32'(m_tgt[2]));
    for (int d = 0; d < 3; d++) begin
      check($sformatf("tv%0d", d),   32'(tv[d]),   32'(m_tv[d]));
      check($sformatf("busy%0d", d), 32'(busy[d]), 32'(m_busy[d]));
      check($sformatf("err%0d", d),  32'(err[d]),  32'(m_err[d]));
    end
  endtask

  task automatic drive(input bit rst, input bit we, input bit ls,
                       input logic [3:0] imm, input logic [7:0] acc,
                       input bit clr, input bit rd, input logic [3:0] ra);
    Reset      = rst;
    Write_En   = we;
    Load_Start = ls;
    Imm_in     = imm;
    Acc_in     = acc;
    Clear      = clr;
    Rd_En      = rd;
    Rd_Addr    = ra;
    for (int d = 0; d < 3; d++) model_step(d);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    // Reset
    drive(1, 0, 0, 0, 8'h00, 0, 0, 0);
    drive(1, 0, 0, 0, 8'h00, 0, 0, 0);
    check("rst_target",  {22'b0, t0}, 32'h0);
    check("rst_valid",   32'(tv[0]),   32'h0);
    check("rst_busy",    32'(busy[0]), 32'h0);
    check("rst_err",     32'(err[0]),  32'h0);

    // Two-beat load to address 3, then lookup.
    drive(0, 1, 1, 4'd3, 8'hA5, 0, 0, 0);
    check("load3_busy", 32'(busy[0]), 32'h1);
    drive(0, 1, 0, 4'd0, 8'h02, 0, 0, 0);
    check("load3_idle", 32'(busy[0]), 32'h0);
    drive(0, 0, 0, 4'd0, 8'h00, 0, 1, 4'd3);
    check("read3_target", {22'b0, t0}, 32'h2A5);
    check("read3_valid",  32'(tv[0]),   32'h1);

    // Partial load is invisible.
    drive(0, 1, 1, 4'd5, 8'h33, 0, 0, 0);
    drive(0, 0, 0, 4'd0, 8'h00, 0, 1, 4'd5);
    check("partial5_target", {22'b0, t0}, 32'h0);
    check("partial5_valid",  32'(tv[0]),   32'h0);
    check("partial5_busy",   32'(busy[0]), 32'h1);

    // Abort by restarting at address 6.
    drive(0, 1, 1, 4'd6, 8'h11, 0, 0, 0);
    check("abort_err_hi", 32'(err[0]), 32'h1);
    drive(0, 1, 0, 4'd0, 8'h01, 0, 0, 0);
    check("abort_err_lo", 32'(err[0]), 32'h0);
    drive(0, 0, 0, 4'd0, 8'h00, 0, 1, 4'd6);
    check("read6_target", {22'b0, t0}, 32'h111);
    check("read6_valid",  32'(tv[0]),   32'h1);
    drive(0, 0, 0, 4'd0, 8'h00, 0, 1, 4'd5);
    check("read5_valid",  32'(tv[0]),   32'h0);

    // Write-first forwarding on address 7.
    drive(0, 1, 1, 4'd7, 8'hFF, 0, 0, 0);
    drive(0, 1, 0, 4'd0, 8'h03, 0, 1, 4'd7);
    check("fwd7_target", {22'b0, t0}, 32'h3FF);
    check("fwd7_valid",  32'(tv[0]),   32'h1);

    // Clear mid-load and after loads.
    drive(0, 1, 1, 4'd9, 8'h44, 0, 0, 0);
    drive(0, 1, 0, 4'd0, 8'h01, 1, 0, 0);
    check("clr_busy", 32'(busy[0]), 32'h0);
    check("clr_err",  32'(err[0]),  32'h0);
    drive(0, 0, 0, 4'd0, 8'h00, 0, 1, 4'd3);
    check("clr_read3_target", {22'b0, t0}, 32'h2A5);
    check("clr_read3_valid",  32'(tv[0]),   32'h0);
    drive(0, 0, 0, 4'd0, 8'h00, 1, 1, 4'd7);
    check("clr_rd7_target", {22'b0, t0}, 32'h3FF);
    check("clr_rd7_valid",  32'(tv[0]),   32'h0);
    check("clr_rd7_err",    32'(err[0]),  32'h0);

    // Three-beat entry (W=24) and one-beat entry (W=8).
    drive(0, 1, 1, 4'd4, 8'h01, 0, 0, 0);
    drive(0, 1, 0, 4'd0, 8'h02, 0, 0, 0);
    check("w24_mid_busy", 32'(busy[1]), 32'h1);
    drive(0, 1, 0, 4'd0, 8'h03, 0, 0, 0);
    drive(0, 0, 0, 4'd0, 8'h00, 0, 1, 4'd4);
    check("w24_target", {8'b0, t1}, 32'h030201);
    check("w24_valid",  32'(tv[1]),  32'h1);
    drive(0, 1, 1, 4'd1, 8'h7E, 0, 0, 0);
    check("w8_busy", 32'(busy[2]), 32'h0);
    drive(0, 0, 0, 4'd0, 8'h00, 0, 1, 4'd1);
    check("w8_target", {24'b0, t2}, 32'h7E);
    check("w8_valid",  32'(tv[2]),   32'h1);

    // Reset mid-load.
    drive(0, 1, 1, 4'd2, 8'hAA, 0, 1, 4'd4);
    drive(1, 1, 0, 4'd0, 8'h55, 0, 1, 4'd4);
    check("rstmid_t1",    {8'b0, t1},  32'h0);
    check("rstmid_tv1",   32'(tv[1]),   32'h0);
    check("rstmid_busy1", 32'(busy[1]), 32'h0);
    check("rstmid_err1",  32'(err[1]),  32'h0);
    check("rstmid_t2",    {24'b0, t2}, 32'h0);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 63) == 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0),
            4'($urandom_range(0, 7)),
            8'($urandom_range(0, 255)),
            ($urandom_range(0, 23) == 0),
            1'($urandom_range(0, 1)),
            4'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
